// File: rtl/inst_rom_loader_if.sv
// Fetch and program-load signals between the core/loader side and the instruction ROM.
// Signal names carry the ROM's point of view (_i into the ROM, _o out of it).
interface inst_rom_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rom_ce_i;
  logic [31:0]       rom_addr_i;
  logic [31:0]       rom_data_o;
  logic              load_start_i;
  logic              load_valid_i;
  logic [31:0]       load_data_i;
  logic              load_last_i;
  logic              load_ready_o;
  logic              load_done_o;
  logic              cpu_hold_o;
  logic [ADDR_W:0]   load_count_o;
  logic              addr_err_o;

  modport master (
    output rom_ce_i, rom_addr_i, load_start_i, load_valid_i, load_data_i, load_last_i,
    input  rom_data_o, load_ready_o, load_done_o, cpu_hold_o, load_count_o, addr_err_o
  );

  modport slave (
    input  rom_ce_i, rom_addr_i, load_start_i, load_valid_i, load_data_i, load_last_i,
    output rom_data_o, load_ready_o, load_done_o, cpu_hold_o, load_count_o, addr_err_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM for the openmips fetch port with a streaming program-load port.
// The core is held in reset until a load completes.
//
//   state  | meaning
//   IDLE   | nothing loaded since reset, core held, waiting for load_start_i
//   LOAD   | accepting image words, core held
//   RUN    | image valid, core released, fetches served
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  inst_rom_loader_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem [DEPTH];
  logic              done_q;
  logic              err_q;
  logic              accept;
  logic              complete;
  logic              fetch_act;
  logic              in_range;
  logic              unused_addr_bits;

  // Write pointer and count move together; count never reaches DEPTH while in LOAD,
  // so its low bits are the write pointer.
  assign wptr      = count[ADDR_W-1:0];
  assign accept    = (state == S_LOAD) && bus.load_valid_i && !bus.load_start_i;
  assign complete  = accept && (bus.load_last_i || (count == LAST_IDX));
  assign idx       = bus.rom_addr_i[ADDR_W+1:2];
  assign in_range  = (bus.rom_addr_i[31:ADDR_W+2] == '0) && ({1'b0, idx} < count);
  assign fetch_act = (state == S_RUN) && bus.rom_ce_i;
  assign unused_addr_bits = ^bus.rom_addr_i[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.load_start_i) state_nxt = S_LOAD;
      S_LOAD:  if (bus.load_start_i) state_nxt = S_LOAD;
               else if (complete)    state_nxt = S_RUN;
      S_RUN:   if (bus.load_start_i) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_hold_o   = 1'b1;
    bus.load_ready_o = 1'b0;
    case (state)
      S_LOAD:  bus.load_ready_o = 1'b1;
      S_RUN:   bus.cpu_hold_o   = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= complete;
      if (bus.load_start_i) count <= '0;
      else if (accept)      count <= count + 1'b1;
      if (fetch_act && !in_range) err_q <= 1'b1;
    end
  end

  // Contents survive reset; a zero count keeps stale words unreachable.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= bus.load_data_i;
  end

  assign bus.rom_data_o   = (fetch_act && in_range) ? mem[idx] : '0;
  assign bus.load_done_o  = done_q;
  assign bus.load_count_o = count;
  assign bus.addr_err_o   = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader against a queue-based image model.
// Two instances: full-size array and a 4-word array for the fill boundary.
module tb_inst_rom_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_rom_loader_if #(.ADDR_W(10)) if0 ();
  inst_rom_loader_if #(.ADDR_W(2))  if1 ();

  inst_rom_loader #(.ADDR_W(10)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  inst_rom_loader #(.ADDR_W(2))  dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int total = 0;
  int bad   = 0;
  bit sel   = 1'b0;

  logic [31:0] o_data, o_count;
  logic        o_ready, o_done, o_hold, o_err;

  always_comb begin
    o_data  = sel ? if1.rom_data_o   : if0.rom_data_o;
    o_count = sel ? 32'(if1.load_count_o) : 32'(if0.load_count_o);
    o_ready = sel ? if1.load_ready_o : if0.load_ready_o;
    o_done  = sel ? if1.load_done_o  : if0.load_done_o;
    o_hold  = sel ? if1.cpu_hold_o   : if0.cpu_hold_o;
    o_err   = sel ? if1.addr_err_o   : if0.addr_err_o;
  end

  // Reference: the loaded image is just a queue of words; its size is the count.
  logic [31:0] img [$];
  bit m_load, m_run, m_done, m_err;
  int depth = 1024;
  int aw    = 10;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] addr);
    int unsigned wi = (addr >> 2) % depth;
    return ((addr >> (aw + 2)) == 0) && (wi < img.size());
  endfunction

  function automatic logic [31:0] exp_data(input bit ce, input logic [31:0] addr);
    if (m_run && ce && in_rng(addr)) return img[(addr >> 2) % depth];
    return 32'h0;
  endfunction

  task automatic model_reset();
    img.delete();
    m_load = 0; m_run = 0; m_done = 0; m_err = 0;
  endtask

  task automatic drive(input bit ce, input logic [31:0] addr, input bit start,
                       input bit valid, input bit last, input logic [31:0] data);
    if0.rom_ce_i = 0; if0.rom_addr_i = 0; if0.load_start_i = 0;
    if0.load_valid_i = 0; if0.load_last_i = 0; if0.load_data_i = 0;
    if1.rom_ce_i = 0; if1.rom_addr_i = 0; if1.load_start_i = 0;
    if1.load_valid_i = 0; if1.load_last_i = 0; if1.load_data_i = 0;
    if (!sel) begin
      if0.rom_ce_i = ce; if0.rom_addr_i = addr; if0.load_start_i = start;
      if0.load_valid_i = valid; if0.load_last_i = last; if0.load_data_i = data;
    end else begin
      if1.rom_ce_i = ce; if1.rom_addr_i = addr; if1.load_start_i = start;
      if1.load_valid_i = valid; if1.load_last_i = last; if1.load_data_i = data;
    end
  endtask

  // One clock: drive, check at the falling edge, advance the model across the rising edge.
  task automatic cyc(input bit ce, input logic [31:0] addr, input bit start,
                     input bit valid, input bit last, input logic [31:0] data);
    drive(ce, addr, start, valid, last, data);
    @(negedge clk);
    chk("rom_data", o_data, exp_data(ce, addr));
    chk("ready", 32'(o_ready), 32'(m_load));
    chk("hold", 32'(o_hold), 32'(!m_run));
    chk("count", o_count, 32'(img.size()));
    chk("done", 32'(o_done), 32'(m_done));
    chk("addr_err", 32'(o_err), 32'(m_err));
    if (m_run && ce && !in_rng(addr)) m_err = 1;
    m_done = 0;
    if (start) begin
      img.delete(); m_load = 1; m_run = 0;
    end else if (m_load && valid) begin
      img.push_back(data);
      if (last || img.size() == depth) begin
        m_load = 0; m_run = 1; m_done = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(input logic [31:0] addr);
    cyc(1, addr, 0, 0, 0, 0);
  endtask

  task automatic word(input logic [31:0] d, input bit last);
    cyc(0, 0, 0, 1, last, d);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom();
      else a = 32'($urandom_range(0, 4 * (img.size() + 2)));
      cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 6) == 0, $urandom());
    end
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    #7;
    chk("rst_hold", 32'(o_hold), 32'd1);
    chk("rst_ready", 32'(o_ready), 32'd0);
    #5 rst = 1'b1;
    @(posedge clk); #1;

    idle();
    fetch(32'h0);
    cyc(0, 0, 0, 1, 0, 32'hDEADBEEF);
    idle();

    cyc(0, 0, 1, 0, 0, 0);
    word(32'h34010001, 0);
    word(32'h34020002, 0);
    word(32'h00221820, 1);
    idle();
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    fetch(32'h9 + 32'($urandom_range(0, 2)));
    fetch(32'hC);
    idle();

    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      idle();
      word($urandom(), i == 5);
    end
    idle();
    for (int i = 0; i < 8; i++) fetch(32'($urandom_range(0, 32)));

    cyc(0, 0, 1, 0, 0, 0);
    word(32'h11111111, 1);
    fetch(32'h0); fetch(32'h4); idle();

    cyc(0, 0, 1, 0, 0, 0);
    word($urandom(), 0); word($urandom(), 0); word($urandom(), 0);
    cyc(0, 0, 1, 1, 0, $urandom());
    word($urandom(), 1);
    fetch(32'h0); fetch(32'h4);

    rand_cycles(300);

    cyc(0, 0, 1, 0, 0, 0);
    word($urandom(), 0); word($urandom(), 0);
    drive(0, 0, 0, 0, 0, 0);
    #3 rst = 1'b0;
    #1;
    chk("arst_hold", 32'(o_hold), 32'd1);
    chk("arst_ready", 32'(o_ready), 32'd0);
    chk("arst_count", o_count, 32'd0);
    chk("arst_done", 32'(o_done), 32'd0);
    chk("arst_err", 32'(o_err), 32'd0);
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    fetch(32'h0); fetch(32'h4); idle();

    sel = 1'b1; depth = 4; aw = 2;
    model_reset();
    idle();
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) word($urandom(), 0);
    idle();
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC); fetch(32'h10);
    idle();
    rand_cycles(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
